bmf_adder_pipe: RTL



---
 rtl/bmf_adder_pkg.sv | 32 +++
 rtl/bmf_adder_lopa_lower.sv | 25 ++
 rtl/bmf_adder_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bmf_adder_pkg.sv
// Shared types and helpers for the pipelined lower-part-OR approximate adder.
// The helpers work on 64-bit containers so that any legal width can share them.
package bmf_adder_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    localparam int STAT_MAX_W = 64;

    // Approximate low part: bitwise OR of the low operand slices.
    function automatic logic [63:0] lopa_low(input logic [63:0] a, input logic [63:0] b);
        return a | b;
    endfunction

    // Carry into the exact upper part: AND of the top approximated bits.
    function automatic logic lopa_carry(input logic a_msb, input logic b_msb);
        return a_msb & b_msb;
    endfunction

    // Add inc to acc and clamp the result to the all-ones value of a width-bit register.
    function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, acc} + {1'b0, inc};
        max = (65'd1 << width) - 65'd1;
        return (sum > max) ? max[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/bmf_adder_lopa_lower.sv
// Combinational lower-part-OR block: OR of the low L bits plus the carry into the upper part.
// With L = 0 there is no approximated part, so the low bits are a 1-bit dummy held at 0.
module lopa_lower
    import bmf_adder_pkg::*;
#(
    parameter int L  = 2,
    parameter int LW = (L > 0) ? L : 1
) (
    input  logic [LW-1:0] a_low,
    input  logic [LW-1:0] b_low,
    output logic [LW-1:0] low,
    output logic          carry
);

    generate
        if (L > 0) begin : g_lopa
            assign low   = LW'(lopa_low(64'(a_low), 64'(b_low)));
            assign carry = lopa_carry(a_low[LW-1], b_low[LW-1]);
        end else begin : g_none
            assign low   = a_low & b_low & '0;
            assign carry = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/bmf_adder_pipe.sv
// Two-stage pipelined approximate adder with valid/ready handshakes and on-line
// error statistics comparing every approximate result with the exact sum.
module bmf_adder_pipe
    import bmf_adder_pkg::*;
#(
    parameter int W          = 8,
    parameter int APPROX_LSB = 2,
    parameter int CNT_W      = 16,
    parameter int ESUM_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic              in_cin,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W:0]        out_sum,
    output logic              out_mode,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ESUM_W-1:0] err_sum
);

    localparam int L  = APPROX_LSB;
    localparam int LW = (L > 0) ? L : 1;
    localparam int UW = (W - L > 0) ? (W - L) : 1;

    generate
        if (W < 2 || L < 0 || L > W) begin : g_bad_width
            $error("bmf_adder_pipe: need W >= 2 and 0 <= APPROX_LSB <= W");
        end
        if (CNT_W < 1 || CNT_W > STAT_MAX_W || ESUM_W < 1 || ESUM_W > STAT_MAX_W) begin : g_bad_stat
            $error("bmf_adder_pipe: statistics widths must be 1..64");
        end
    endgenerate

    // ---------------- stage 1: split operands, exact sum ----------------
    logic [LW-1:0] a_low;
    logic [LW-1:0] b_low;
    logic [UW-1:0] a_hi;
    logic [UW-1:0] b_hi;
    logic [LW-1:0] low_next;
    logic          carry_next;
    logic [W:0]    exact_next;

    assign a_low = in_a[LW-1:0];
    assign b_low = in_b[LW-1:0];

    generate
        if (L < W) begin : g_hi
            assign a_hi = in_a[W-1:W-UW];
            assign b_hi = in_b[W-1:W-UW];
        end else begin : g_no_hi
            assign a_hi = '0;
            assign b_hi = '0;
        end
    endgenerate

    lopa_lower #(
        .L  (L),
        .LW (LW)
    ) u_lopa (
        .a_low (a_low),
        .b_low (b_low),
        .low   (low_next),
        .carry (carry_next)
    );

    assign exact_next = {1'b0, in_a} + {1'b0, in_b} + (W + 1)'(in_cin);

    logic          s1_valid_reg;
    logic [LW-1:0] s1_low_reg;
    logic          s1_carry_reg;
    logic [UW-1:0] s1_a_hi_reg;
    logic [UW-1:0] s1_b_hi_reg;
    mode_e         s1_mode_reg;
    logic [W:0]    s1_exact_reg;

    logic s2_adv;
    logic out_valid_reg;

    assign s2_adv   = !out_valid_reg || out_ready;
    assign in_ready = !s1_valid_reg || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_low_reg   <= '0;
            s1_carry_reg <= 1'b0;
            s1_a_hi_reg  <= '0;
            s1_b_hi_reg  <= '0;
            s1_mode_reg  <= MODE_EXACT;
            s1_exact_reg <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_low_reg   <= low_next;
                s1_carry_reg <= carry_next;
                s1_a_hi_reg  <= a_hi;
                s1_b_hi_reg  <= b_hi;
                s1_mode_reg  <= mode_e'(in_mode);
                s1_exact_reg <= exact_next;
            end
        end
    end

    // ---------------- stage 2: assemble result, error distance ----------------
    logic [W:0] approx_sum;
    logic [W:0] sum_next;
    logic [W:0] dist_next;

    generate
        if (L == 0) begin : g_all_exact
            assign approx_sum = s1_exact_reg;
        end else if (L == W) begin : g_all_approx
            assign approx_sum = {s1_carry_reg, s1_low_reg};
        end else begin : g_split
            logic [UW:0] upper;
            assign upper      = {1'b0, s1_a_hi_reg} + {1'b0, s1_b_hi_reg} + (UW + 1)'(s1_carry_reg);
            assign approx_sum = {upper, s1_low_reg};
        end
    endgenerate

    // Exact-mode results carry a zero distance, so they can never disturb the statistics.
    always_comb begin
        sum_next  = s1_exact_reg;
        dist_next = '0;
        if (s1_mode_reg == MODE_APPROX) begin
            sum_next  = approx_sum;
            dist_next = (s1_exact_reg >= approx_sum) ? (s1_exact_reg - approx_sum)
                                                     : (approx_sum - s1_exact_reg);
        end
    end

    logic [W:0] out_sum_reg;
    mode_e      out_mode_reg;
    logic [W:0] s2_dist_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_mode_reg  <= MODE_EXACT;
            s2_dist_reg   <= '0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_sum_reg  <= sum_next;
                out_mode_reg <= s1_mode_reg;
                s2_dist_reg  <= dist_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_mode  = out_mode_reg;

    // ---------------- saturating statistics ----------------
    logic              stat_upd;
    logic [CNT_W-1:0]  err_cnt_reg;
    logic [ESUM_W-1:0] err_sum_reg;

    assign stat_upd = out_valid_reg && out_ready && (out_mode_reg == MODE_APPROX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
            err_sum_reg <= '0;
        end else if (stat_clr) begin
            err_cnt_reg <= '0;
            err_sum_reg <= '0;
        end else if (stat_upd) begin
            err_cnt_reg <= CNT_W'(sat_add(64'(err_cnt_reg), 64'(s2_dist_reg != '0), CNT_W));
            err_sum_reg <= ESUM_W'(sat_add(64'(err_sum_reg), 64'(s2_dist_reg), ESUM_W));
        end
    end

    assign err_cnt = err_cnt_reg;
    assign err_sum = err_sum_reg;

endmodule
